// File: rtl/addsub_rr_scheduler_if.sv
// Request/response bundle for the shared add/sub scheduler.
// master: the requesters and the result consumer; slave: the scheduler.
interface addsub_rr_scheduler_if #(
    parameter int unsigned N = 8,
    parameter int unsigned M = 4
);
    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_a;
    logic [M-1:0] req0_b;
    logic         req0_sub;

    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_a;
    logic [M-1:0] req1_b;
    logic         req1_sub;

    logic         resp_valid;
    logic         resp_ready;
    logic         resp_id;
    logic [N-1:0] resp_s;
    logic         resp_ovf;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_sub,
        input  req1_ready,
        input  resp_valid, resp_id, resp_s, resp_ovf,
        output resp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_sub,
        output req1_ready,
        output resp_valid, resp_id, resp_s, resp_ovf,
        input  resp_ready
    );
endinterface

// File: rtl/addsub_rr_scheduler.sv
// Two requesters share one signed add/subtract datapath. A round-robin FSM
// grants one request at a time; the registered result (with signed overflow
// and requester ID) is held until the consumer accepts it.
module addsub_rr_scheduler #(
    parameter int unsigned N = 8,
    parameter int unsigned M = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    addsub_rr_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next_state;

    logic         r_last_grant;
    logic [N-1:0] r_a;
    logic [M-1:0] r_b;
    logic         r_sub;
    logic         r_id;

    logic         r_resp_valid;
    logic         r_resp_id;
    logic [N-1:0] r_resp_s;
    logic         r_resp_ovf;

    logic         w_grant_valid;
    logic         w_grant_id;
    logic         w_ready0;
    logic         w_ready1;
    logic         w_accept;

    logic [N-1:0] w_ext_b;
    logic [N-1:0] w_opb;
    logic [N-1:0] w_low;
    logic [1:0]   w_top;
    logic [N-1:0] w_s;
    logic         w_ovf;

    // Round-robin pick: a tie goes to the requester that did not win last time.
    always_comb begin
        w_grant_valid = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant_id = ~r_last_grant;
        end else begin
            w_grant_id = bus.req1_valid;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; a response handshake always passes through IDLE
    // before the next request can be accepted.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_grant_valid) w_next_state = EXEC;
            EXEC:    w_next_state = RESP;
            RESP:    if (bus.resp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // FSM outputs: ready only to the granted requester, only while idle.
    always_comb begin
        w_ready0 = 1'b0;
        w_ready1 = 1'b0;
        if (r_state == IDLE && w_grant_valid) begin
            w_ready0 = ~w_grant_id;
            w_ready1 = w_grant_id;
        end
        w_accept = (w_ready0 & bus.req0_valid) | (w_ready1 & bus.req1_valid);
    end

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;

    // Operand capture on acceptance; remembers the winner for the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_sub        <= 1'b0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_a          <= w_grant_id ? bus.req1_a   : bus.req0_a;
            r_b          <= w_grant_id ? bus.req1_b   : bus.req0_b;
            r_sub        <= w_grant_id ? bus.req1_sub : bus.req0_sub;
            r_id         <= w_grant_id;
            r_last_grant <= w_grant_id;
        end
    end

    // Adder split at the sign bit so the carry into and out of bit N-1 are
    // both visible; their XOR is the signed overflow. Subtraction inverts the
    // extended b and injects sub as carry-in.
    always_comb begin
        w_ext_b = N'(signed'(r_b));
        w_opb   = w_ext_b ^ {N{r_sub}};
        w_low   = {1'b0, r_a[N-2:0]} + {1'b0, w_opb[N-2:0]} + N'(r_sub);
        w_top   = 2'(r_a[N-1]) + 2'(w_opb[N-1]) + 2'(w_low[N-1]);
        w_s     = {w_top[0], w_low[N-2:0]};
        w_ovf   = w_top[1] ^ w_low[N-1];
    end

    // Response registers: loaded in EXEC, held through RESP until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_s     <= '0;
            r_resp_ovf   <= 1'b0;
        end else if (r_state == EXEC) begin
            r_resp_valid <= 1'b1;
            r_resp_id    <= r_id;
            r_resp_s     <= w_s;
            r_resp_ovf   <= w_ovf;
        end else if (r_state == RESP && bus.resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_id    = r_resp_id;
    assign bus.resp_s     = r_resp_s;
    assign bus.resp_ovf   = r_resp_ovf;
endmodule
